collision_detector: RTL and testbench

Per-frame hit detector between the player sprite and enemy bullets. It produces the single-cycle `collision` pulse that drives `health_stateMachine`, plus a per-bullet kill strobe back to the bullet controller. After each hit it enforces an invulnerability window measured in frames, so one bullet or bullet cluster costs exactly one health point.

---
 rtl/collision_pkg.sv | 18 +
 rtl/aabb_overlap.sv | 32 +++
 rtl/collision_detector.sv | 135 +++++++++++++
 tb/tb_collision_detector.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and defaults for the player/bullet collision detector.
package collision_pkg;

  localparam int unsigned COORD_W_DFLT = 10;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT,
    COOLDOWN
  } cd_state_t;

  typedef struct packed {
    logic [COORD_W_DFLT-1:0] x;
    logic [COORD_W_DFLT-1:0] y;
  } bbox_t;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test; box A at (a_x,a_y), box B at (b_x,b_y).
module aabb_overlap #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned A_W     = 16,
  parameter int unsigned A_H     = 16,
  parameter int unsigned B_W     = 4,
  parameter int unsigned B_H     = 4
) (
  input  logic [COORD_W-1:0] a_x,
  input  logic [COORD_W-1:0] a_y,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  output logic               overlap
);

  // One extra bit so far edges near the screen limit never wrap.
  logic [COORD_W:0] ax, ay, bx, by;
  logic [COORD_W:0] ax_end, ay_end, bx_end, by_end;

  always_comb begin
    ax     = {1'b0, a_x};
    ay     = {1'b0, a_y};
    bx     = {1'b0, b_x};
    by     = {1'b0, b_y};
    ax_end = ax + (COORD_W+1)'(A_W - 1);
    ay_end = ay + (COORD_W+1)'(A_H - 1);
    bx_end = bx + (COORD_W+1)'(B_W - 1);
    by_end = by + (COORD_W+1)'(B_H - 1);
    overlap = (bx <= ax_end) && (ax <= bx_end) && (by <= ay_end) && (ay <= by_end);
  end

endmodule

// File: rtl/collision_detector.sv
// Per-frame player vs. bullet hit scan with a frame-counted invulnerability window.
module collision_detector
  import collision_pkg::*;
#(
  parameter int unsigned NUM_BULLETS   = 8,
  parameter int unsigned COORD_W       = COORD_W_DFLT,
  parameter int unsigned PLAYER_W      = 16,
  parameter int unsigned PLAYER_H      = 16,
  parameter int unsigned BULLET_SIZE   = 4,
  parameter int unsigned INVULN_FRAMES = 60
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_tick,
  input  logic                           gameEnd,
  input  logic [COORD_W-1:0]             player_x,
  input  logic [COORD_W-1:0]             player_y,
  input  logic [NUM_BULLETS*COORD_W-1:0] bullet_x,
  input  logic [NUM_BULLETS*COORD_W-1:0] bullet_y,
  input  logic [NUM_BULLETS-1:0]         bullet_valid,
  output logic                           collision,
  output logic [NUM_BULLETS-1:0]         bullet_kill,
  output logic [$clog2(NUM_BULLETS)-1:0] hit_index,
  output logic                           invulnerable,
  output logic                           scan_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_BULLETS);
  localparam int unsigned CNT_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

  cd_state_t        state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [COORD_W-1:0] px, py, cur_bx, cur_by;
  logic             cur_valid, overlap, hit, last_slot, cool_done;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    cur_bx    = '0;
    cur_by    = '0;
    cur_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_bx    = bullet_x[i*COORD_W +: COORD_W];
        cur_by    = bullet_y[i*COORD_W +: COORD_W];
        cur_valid = bullet_valid[i];
      end
    end
  end

  aabb_overlap #(
    .COORD_W(COORD_W),
    .A_W    (PLAYER_W),
    .A_H    (PLAYER_H),
    .B_W    (BULLET_SIZE),
    .B_H    (BULLET_SIZE)
  ) u_overlap (
    .a_x    (px),
    .a_y    (py),
    .b_x    (cur_bx),
    .b_y    (cur_by),
    .overlap(overlap)
  );

  assign hit       = cur_valid && overlap;
  assign last_slot = (idx == IDX_W'(NUM_BULLETS - 1));
  assign cool_done = frame_tick && (cnt == CNT_W'(1));

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (gameEnd) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (frame_tick) state_nxt = SCAN;
        SCAN: begin
          if (hit)            state_nxt = REPORT;
          else if (last_slot) state_nxt = IDLE;
        end
        REPORT:   state_nxt = (INVULN_FRAMES == 0) ? IDLE : COOLDOWN;
        COOLDOWN: if (cool_done) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Pulses are raised on the edge entering REPORT so they are visible exactly during REPORT.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx         <= '0;
      px          <= '0;
      py          <= '0;
      cnt         <= '0;
      collision   <= 1'b0;
      bullet_kill <= '0;
      hit_index   <= '0;
    end else begin
      collision   <= 1'b0;
      bullet_kill <= '0;
      if (gameEnd) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (frame_tick) begin
              px  <= player_x;
              py  <= player_y;
              idx <= '0;
            end
          end
          SCAN: begin
            if (hit) begin
              collision   <= 1'b1;
              bullet_kill <= NUM_BULLETS'(1) << idx;
              hit_index   <= idx;
            end else if (!last_slot) begin
              idx <= idx + IDX_W'(1);
            end
          end
          REPORT:   cnt <= CNT_W'(INVULN_FRAMES);
          COOLDOWN: if (frame_tick) cnt <= cnt - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign scan_busy    = (state == SCAN);
  assign invulnerable = (state == REPORT) || (state == COOLDOWN);

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench: timestamp-based behavioural model plus directed and random frames.
module tb_collision_detector;

  localparam int NB  = 8;
  localparam int CW  = 10;
  localparam int PW  = 16;
  localparam int PH  = 16;
  localparam int BS  = 4;
  localparam int INV = 3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic          gameEnd = 1'b0;
  logic [CW-1:0] player_x = '0;
  logic [CW-1:0] player_y = '0;
  logic [CW-1:0] bxs [NB];
  logic [CW-1:0] bys [NB];
  logic [NB*CW-1:0] bullet_x, bullet_y;
  logic [NB-1:0] bullet_valid = '0;
  logic          collision;
  logic [NB-1:0] bullet_kill;
  logic [2:0]    hit_index;
  logic          invulnerable, scan_busy;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NB; g++) begin : g_pack
    assign bullet_x[g*CW +: CW] = bxs[g];
    assign bullet_y[g*CW +: CW] = bys[g];
  end

  collision_detector #(
    .NUM_BULLETS  (NB),
    .COORD_W      (CW),
    .PLAYER_W     (PW),
    .PLAYER_H     (PH),
    .BULLET_SIZE  (BS),
    .INVULN_FRAMES(INV)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .gameEnd     (gameEnd),
    .player_x    (player_x),
    .player_y    (player_y),
    .bullet_x    (bullet_x),
    .bullet_y    (bullet_y),
    .bullet_valid(bullet_valid),
    .collision   (collision),
    .bullet_kill (bullet_kill),
    .hit_index   (hit_index),
    .invulnerable(invulnerable),
    .scan_busy   (scan_busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Lowest-index valid bullet overlapping the player, in unbounded integer arithmetic.
  function automatic int first_hit();
    int px = int'(player_x);
    int py = int'(player_y);
    for (int i = 0; i < NB; i++) begin
      int bx = int'(bxs[i]);
      int by = int'(bys[i]);
      if (bullet_valid[i] && bx <= px + PW - 1 && px <= bx + BS - 1 &&
          by <= py + PH - 1 && py <= by + BS - 1)
        return i;
    end
    return -1;
  endfunction

  // Model: a frame starts at edge t0; scan spans k+1 (hit) or NB edges, then report, then cooldown ticks.
  int edge_n = 0, t0 = -1, mk = -1, ticks_seen = 0, m_valid = 0;
  int exp_coll = 0, exp_kill = 0, exp_hidx = 0, exp_busy = 0, exp_inv = 0;

  initial forever begin
    int rel;
    @(posedge Clk);
    exp_coll = 0;
    exp_kill = 0;
    if (Reset) begin
      t0 = -1; ticks_seen = 0; exp_hidx = 0; m_valid = 1;
    end else if (gameEnd) begin
      t0 = -1;
    end else if (t0 < 0) begin
      if (frame_tick) begin
        t0 = edge_n; mk = first_hit(); ticks_seen = 0;
      end
    end else begin
      rel = edge_n - t0;
      if (mk < 0) begin
        if (rel == NB) t0 = -1;
      end else if (rel == mk + 1) begin
        exp_coll = 1; exp_kill = 1 << mk; exp_hidx = mk;
        if (INV == 0) t0 = -1;
      end else if (rel >= mk + 3 && frame_tick) begin
        ticks_seen++;
        if (ticks_seen == INV) t0 = -1;
      end
    end
    rel = edge_n - t0;
    exp_busy = (t0 >= 0) && (rel < ((mk < 0) ? NB : mk + 1));
    exp_inv  = (t0 >= 0) && (mk >= 0) && (rel >= mk + 1);
    edge_n++;
  end

  initial forever begin
    @(negedge Clk);
    if (m_valid != 0) begin
      check("collision",    int'(collision),    exp_coll);
      check("bullet_kill",  int'(bullet_kill),  exp_kill);
      check("hit_index",    int'(hit_index),    exp_hidx);
      check("scan_busy",    int'(scan_busy),    exp_busy);
      check("invulnerable", int'(invulnerable), exp_inv);
    end
  end

  task automatic clear_state();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    bullet_valid = '0;
  endtask

  task automatic place(input int i, input int x, input int y);
    bxs[i] = CW'(x);
    bys[i] = CW'(y);
    bullet_valid[i] = 1'b1;
  endtask

  // Issue one frame_tick and observe 14 cycles; optional retick / gameEnd / Reset at cycle n.
  task automatic run_frame(input int retick_at, input int ge_at, input int rst_at,
                           output int hit_at, output int kill_seen,
                           output int pulses, output int busy);
    hit_at = -1; kill_seen = 0; pulses = 0; busy = 0;
    frame_tick = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge Clk);
      if (collision) begin
        pulses++;
        if (hit_at < 0) begin hit_at = n; kill_seen = int'(bullet_kill); end
      end
      if (scan_busy) busy++;
      frame_tick = (n == retick_at);
      gameEnd    = (ge_at > 0) && (n >= ge_at);
      Reset      = (n == rst_at);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  task automatic randomize_scene();
    int px, py;
    px = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023));
    py = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023));
    player_x = CW'(px);
    player_y = CW'(py);
    for (int i = 0; i < NB; i++) begin
      bullet_valid[i] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        bxs[i] = CW'(clamp(px + int'($urandom_range(0, 40)) - 20));
        bys[i] = CW'(clamp(py + int'($urandom_range(0, 40)) - 20));
      end else begin
        bxs[i] = CW'($urandom_range(0, 1023));
        bys[i] = CW'($urandom_range(0, 1023));
      end
    end
  endtask

  initial begin
    int hit_at, kill, pulses, busy, ge_left;
    for (int i = 0; i < NB; i++) begin bxs[i] = '0; bys[i] = '0; end
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_collision", int'(collision), 0);
    check("rst_kill",      int'(bullet_kill), 0);
    check("rst_index",     int'(hit_index), 0);
    check("rst_invuln",    int'(invulnerable), 0);
    check("rst_busy",      int'(scan_busy), 0);
    Reset = 1'b0;
    @(negedge Clk);

    player_x = 10'd100; player_y = 10'd100;
    place(3, 110, 112);
    run_frame(0, 0, 0, hit_at, kill, pulses, busy);
    check("t1_latency", hit_at, 5);
    check("t1_kill", kill, 8);
    check("t1_pulses", pulses, 1);
    check("t1_busy", busy, 4);
    check("t1_index", int'(hit_index), 3);
    check("t1_invuln", int'(invulnerable), 1);

    clear_state();
    place(2, 100, 100);
    place(5, 105, 105);
    run_frame(0, 0, 0, hit_at, kill, pulses, busy);
    check("multi_latency", hit_at, 4);
    check("multi_kill", kill, 4);
    check("multi_pulses", pulses, 1);

    clear_state();
    place(0, 116, 100);
    run_frame(0, 0, 0, hit_at, kill, pulses, busy);
    check("touch_pulses", pulses, 0);
    check("touch_busy", busy, 8);
    place(0, 115, 100);
    run_frame(0, 0, 0, hit_at, kill, pulses, busy);
    check("edge_latency", hit_at, 2);
    check("edge_kill", kill, 1);

    clear_state();
    player_x = 10'd1016; player_y = 10'd1016;
    place(0, 3, 3);
    run_frame(0, 0, 0, hit_at, kill, pulses, busy);
    check("wrap_nohit", pulses, 0);
    place(1, 1022, 1022);
    run_frame(0, 0, 0, hit_at, kill, pulses, busy);
    check("wrap_latency", hit_at, 3);
    check("wrap_kill", kill, 2);

    clear_state();
    player_x = 10'd200; player_y = 10'd200;
    place(0, 200, 200);
    run_frame(0, 0, 0, hit_at, kill, pulses, busy);
    check("cool_first", hit_at, 2);
    for (int f = 1; f <= 3; f++) begin
      run_frame(0, 0, 0, hit_at, kill, pulses, busy);
      check("cool_blocked", pulses, 0);
    end
    check("cool_released", int'(invulnerable), 0);
    run_frame(0, 0, 0, hit_at, kill, pulses, busy);
    check("cool_rehit", hit_at, 2);

    clear_state();
    player_x = 10'd300; player_y = 10'd300;
    place(5, 305, 310);
    run_frame(0, 2, 0, hit_at, kill, pulses, busy);
    check("ge_pulses", pulses, 0);
    check("ge_busy", busy, 2);
    check("ge_invuln", int'(invulnerable), 0);
    check("ge_kill", int'(bullet_kill), 0);
    gameEnd = 1'b0;
    @(negedge Clk);
    run_frame(0, 0, 2, hit_at, kill, pulses, busy);
    check("rst_mid_pulses", pulses, 0);
    check("rst_mid_busy", busy, 2);
    check("rst_mid_invuln", int'(invulnerable), 0);

    clear_state();
    place(7, 300, 300);
    run_frame(3, 0, 0, hit_at, kill, pulses, busy);
    check("retick_latency", hit_at, 9);
    check("retick_pulses", pulses, 1);
    check("retick_busy", busy, 8);

    clear_state();
    ge_left = 0;
    for (int c = 0; c < 5000; c++) begin
      frame_tick = 1'b0;
      Reset = 1'b0;
      if (exp_busy == 0 && $urandom_range(0, 3) == 0) randomize_scene();
      if ($urandom_range(0, 5) == 0) frame_tick = 1'b1;
      if (ge_left > 0) ge_left--;
      else if ($urandom_range(0, 199) == 0) ge_left = int'($urandom_range(1, 4));
      gameEnd = (ge_left > 0);
      if ($urandom_range(0, 499) == 0) Reset = 1'b1;
      @(negedge Clk);
    end
    frame_tick = 1'b0;
    gameEnd = 1'b0;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
